// File: rtl/dma_engine_if.sv
// dma_engine_if: groups the CPU command/stall signals and the SRAM/DRAM buses of the DMA engine.
//   master : the DMA engine (drives memory requests, write data and stall)
//   slave  : the surrounding system (CPU command, SRAM array, DRAM controller)
//   dmaCmd/dmaSrcAddress/dmaDstAddress/dmaWidth : one-cycle transfer command from the CPU
//   sram*  : SRAM word port; sramReadData is a combinational read of sramAddress
//   dram*  : DRAM byte-addressed request port; dramValid completes the current request
//   stall  : high while a transfer is in progress
interface dma_engine_if #(
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned WIDTH_W = 10
);
    logic [1:0]         dmaCmd;
    logic [31:0]        dmaSrcAddress;
    logic [31:0]        dmaDstAddress;
    logic [WIDTH_W-1:0] dmaWidth;
    logic               stall;

    logic [SRAM_AW-1:0] sramAddress;
    logic [31:0]        sramWriteData;
    logic               sramWriteEnable;
    logic [31:0]        sramReadData;

    logic [31:0]        dramAddress;
    logic [31:0]        dramWriteData;
    logic               dramWriteEnable;
    logic               dramReadEnable;
    logic [31:0]        dramReadData;
    logic               dramValid;

    modport master (
        input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth, sramReadData, dramReadData,
               dramValid,
        output stall, sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
               dramWriteEnable, dramReadEnable
    );

    modport slave (
        output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth, sramReadData, dramReadData,
               dramValid,
        input  stall, sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
               dramWriteEnable, dramReadEnable
    );
endinterface

// File: rtl/dma_engine.sv
// dma_engine: word-granular DMA between DRAM and the on-chip data SRAM.
// A one-cycle dmaCmd (01 = DRAM->SRAM, 10 = SRAM->DRAM) with non-zero dmaWidth starts a transfer of
// dmaWidth 32-bit words; stall is held high (registered) until the last word has moved.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high; aborts any transfer and zeroes all outputs
//   bus   : dma_engine_if.master (command, stall, SRAM port, DRAM request port)
module dma_engine #(
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned WIDTH_W = 10
) (
    input logic          clk,
    input logic          reset,
    dma_engine_if.master bus
);
    typedef enum logic [1:0] {Idle, RdDram, WrSram, S2dWr} state_t;

    state_t             state;
    logic [31:0]        srcAddr;
    logic [31:0]        dstAddr;
    logic [WIDTH_W-1:0] width;
    logic [WIDTH_W-1:0] cnt;

    logic [SRAM_AW-1:0] sramAddressReg;
    logic [31:0]        sramWriteDataReg;
    logic               sramWriteEnableReg;
    logic [31:0]        dramAddressReg;
    logic               dramReadEnableReg;
    logic               dramWriteEnableReg;
    logic               stallReg;

    logic [WIDTH_W-1:0] cntNext;
    logic [31:0]        offCur;
    logic [31:0]        offNext;
    logic [31:0]        srcNext;
    logic [31:0]        dstSel;
    logic               lastWord;

    assign cntNext  = cnt + WIDTH_W'(1);
    assign offCur   = 32'({cnt, 2'b00});
    assign offNext  = 32'({cntNext, 2'b00});
    assign srcNext  = srcAddr + offNext;
    // In RdDram the SRAM write address for the current word is needed; in S2dWr the DRAM address
    // of the following word. One adder serves both.
    assign dstSel   = dstAddr + ((state == RdDram) ? offCur : offNext);
    assign lastWord = (cntNext == width);

    assign bus.sramAddress     = sramAddressReg;
    assign bus.sramWriteData   = sramWriteDataReg;
    assign bus.sramWriteEnable = sramWriteEnableReg;
    assign bus.dramAddress     = dramAddressReg;
    assign bus.dramReadEnable  = dramReadEnableReg;
    assign bus.dramWriteEnable = dramWriteEnableReg;
    assign bus.stall           = stallReg;
    // SRAM read is combinational, so the word being written to DRAM follows sramAddress directly.
    assign bus.dramWriteData   = (state == S2dWr) ? bus.sramReadData : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= Idle;
            srcAddr            <= '0;
            dstAddr            <= '0;
            width              <= '0;
            cnt                <= '0;
            sramAddressReg     <= '0;
            sramWriteDataReg   <= '0;
            sramWriteEnableReg <= 1'b0;
            dramAddressReg     <= '0;
            dramReadEnableReg  <= 1'b0;
            dramWriteEnableReg <= 1'b0;
            stallReg           <= 1'b0;
        end else begin
            unique case (state)
                Idle: begin
                    if ((bus.dmaCmd == 2'b01 || bus.dmaCmd == 2'b10) && bus.dmaWidth != '0) begin
                        srcAddr  <= bus.dmaSrcAddress;
                        dstAddr  <= bus.dmaDstAddress;
                        width    <= bus.dmaWidth;
                        cnt      <= '0;
                        stallReg <= 1'b1;
                        if (bus.dmaCmd == 2'b01) begin
                            state             <= RdDram;
                            dramReadEnableReg <= 1'b1;
                            dramAddressReg    <= bus.dmaSrcAddress;
                        end else begin
                            state              <= S2dWr;
                            sramAddressReg     <= bus.dmaSrcAddress[SRAM_AW+1:2];
                            dramWriteEnableReg <= 1'b1;
                            dramAddressReg     <= bus.dmaDstAddress;
                        end
                    end
                end
                RdDram: begin
                    if (bus.dramValid) begin
                        state              <= WrSram;
                        dramReadEnableReg  <= 1'b0;
                        dramAddressReg     <= '0;
                        sramWriteEnableReg <= 1'b1;
                        sramAddressReg     <= dstSel[SRAM_AW+1:2];
                        sramWriteDataReg   <= bus.dramReadData;
                    end
                end
                WrSram: begin
                    sramWriteEnableReg <= 1'b0;
                    sramAddressReg     <= '0;
                    sramWriteDataReg   <= '0;
                    cnt                <= cntNext;
                    if (lastWord) begin
                        state    <= Idle;
                        stallReg <= 1'b0;
                    end else begin
                        state             <= RdDram;
                        dramReadEnableReg <= 1'b1;
                        dramAddressReg    <= srcNext;
                    end
                end
                S2dWr: begin
                    if (bus.dramValid) begin
                        cnt <= cntNext;
                        if (lastWord) begin
                            state              <= Idle;
                            stallReg           <= 1'b0;
                            dramWriteEnableReg <= 1'b0;
                            dramAddressReg     <= '0;
                            sramAddressReg     <= '0;
                        end else begin
                            sramAddressReg <= srcNext[SRAM_AW+1:2];
                            dramAddressReg <= dstSel;
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: scoreboard bench for dma_engine with behavioural SRAM and a fixed-latency DRAM.
module tb_dma_engine;
    localparam int unsigned SRAM_AW = 14;
    localparam int unsigned WIDTH_W = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dma_engine_if #(.SRAM_AW(SRAM_AW), .WIDTH_W(WIDTH_W)) bus ();

    dma_engine #(.SRAM_AW(SRAM_AW), .WIDTH_W(WIDTH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkEq(input string tag, input logic [63:0] observed,
                           input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Memory models and scoreboard queues
    logic [31:0] sram [0:(1<<SRAM_AW)-1];
    logic [31:0] dram [logic [31:0]];
    logic [63:0] expSram[$];
    logic [63:0] expDramWr[$];
    logic [31:0] expRdReq[$];

    int latency = 1;
    int latCnt = 0;
    int stallCycles = 0;
    int sramWrites = 0;
    int dramReqs = 0;
    int cycle = 0;
    int lastSramCycle = 0;
    int lastDramWrCycle = 0;

    assign bus.sramReadData = sram[bus.sramAddress];

    logic anyActive;
    assign anyActive = bus.stall | bus.sramWriteEnable | bus.dramReadEnable | bus.dramWriteEnable |
                       (|bus.sramAddress) | (|bus.dramAddress) | (|bus.sramWriteData) |
                       (|bus.dramWriteData);

    always @(posedge clk) cycle++;

    // Monitor + DRAM responder: dramValid is raised on the latency-th cycle a request is held.
    always @(negedge clk) begin
        if (bus.stall) stallCycles++;
        if (bus.sramWriteEnable) begin
            sramWrites++;
            lastSramCycle = cycle;
            if (expSram.size() == 0)
                checkEq("sram_wr_unexpected", 64'(expSram.size()), 64'd1);
            else
                checkEq("sram_wr", {bus.sramAddress, bus.sramWriteData}, expSram.pop_front());
            sram[bus.sramAddress] = bus.sramWriteData;
        end
        if (bus.dramReadEnable || bus.dramWriteEnable) begin
            if (latCnt >= latency - 1) begin
                latCnt = 0;
                bus.dramValid = 1'b1;
                dramReqs++;
                if (bus.dramReadEnable) begin
                    bus.dramReadData = dram.exists(bus.dramAddress) ? dram[bus.dramAddress]
                                                                    : 32'h0;
                    if (expRdReq.size() == 0)
                        checkEq("dram_rd_unexpected", 64'(expRdReq.size()), 64'd1);
                    else
                        checkEq("dram_rd_addr", 64'(bus.dramAddress), 64'(expRdReq.pop_front()));
                end else begin
                    lastDramWrCycle = cycle;
                    dram[bus.dramAddress] = bus.dramWriteData;
                    if (expDramWr.size() == 0)
                        checkEq("dram_wr_unexpected", 64'(expDramWr.size()), 64'd1);
                    else
                        checkEq("dram_wr", {bus.dramAddress, bus.dramWriteData},
                                expDramWr.pop_front());
                end
            end else begin
                latCnt++;
                bus.dramValid = 1'b0;
            end
        end else begin
            latCnt = 0;
            bus.dramValid = 1'b0;
            bus.dramReadData = 32'h0;
        end
    end

    function automatic logic [63:0] sramEntry(input logic [31:0] byteAddr, input int i,
                                              input logic [31:0] data);
        logic [31:0] word;
        word = ((byteAddr >> 2) + 32'(i)) & ((32'd1 << SRAM_AW) - 32'd1);
        return {word, data};
    endfunction

    task automatic launch(input logic [1:0] cmd, input logic [31:0] s, input logic [31:0] d,
                          input int w);
        @(negedge clk);
        bus.dmaCmd        = cmd;
        bus.dmaSrcAddress = s;
        bus.dmaDstAddress = d;
        bus.dmaWidth      = w[WIDTH_W-1:0];
        @(negedge clk);
        bus.dmaCmd = 2'b00;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (bus.stall && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkEq(tag, 64'(bus.stall), 64'd0);
    endtask

    task automatic checkQuiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkEq(tag, 64'(anyActive), 64'd0);
        end
    endtask

    initial begin
        int n;
        reset             = 1'b1;
        bus.dmaCmd        = 2'b00;
        bus.dmaSrcAddress = 32'h0;
        bus.dmaDstAddress = 32'h0;
        bus.dmaWidth      = '0;
        repeat (2) @(negedge clk);
        checkEq("rst_ctrl", {bus.stall, bus.sramWriteEnable, bus.dramReadEnable,
                             bus.dramWriteEnable}, 64'd0);
        checkEq("rst_sram_addr", 64'(bus.sramAddress), 64'd0);
        checkEq("rst_dram_addr", 64'(bus.dramAddress), 64'd0);
        checkEq("rst_wdata", {bus.sramWriteData, bus.dramWriteData}, 64'd0);
        reset = 1'b0;

        // Idle with no command
        checkQuiet("idle_quiet", 20);

        // DRAM -> SRAM, latency 3
        latency = 3;
        for (int i = 0; i < 4; i++) begin
            dram[32'h100 + 4*i] = 32'hA0 + i;
            expRdReq.push_back(32'h100 + 4*i);
            expSram.push_back(sramEntry(32'h40, i, 32'hA0 + i));
        end
        stallCycles = 0;
        launch(2'b01, 32'h100, 32'h40, 4);
        waitDone("d2s_done");
        checkEq("d2s_stall_cycles", 64'(stallCycles), 64'd16);
        for (int i = 0; i < 4; i++) checkEq("d2s_sram_word", 64'(sram[32'h10 + i]), 64'hA0 + i);
        checkEq("d2s_queues", 64'(expSram.size() + expRdReq.size()), 64'd0);

        // SRAM -> DRAM, latency 1
        latency = 1;
        for (int i = 0; i < 3; i++) begin
            sram[32'h20 + i] = 32'(i + 1);
            expDramWr.push_back({32'h2000 + 32'(4*i), 32'(i + 1)});
        end
        stallCycles = 0;
        n = sramWrites;
        launch(2'b10, 32'h80, 32'h2000, 3);
        waitDone("s2d_done");
        checkEq("s2d_stall_cycles", 64'(stallCycles), 64'd3);
        checkEq("s2d_no_sram_wr", 64'(sramWrites), 64'(n));
        checkEq("s2d_queue", 64'(expDramWr.size()), 64'd0);

        // Ignored commands
        n = dramReqs + sramWrites;
        launch(2'b01, 32'h100, 32'h40, 0);
        checkQuiet("width0_quiet", 5);
        launch(2'b11, 32'h100, 32'h40, 4);
        checkQuiet("cmd11_quiet", 5);
        checkEq("ignored_no_traffic", 64'(dramReqs + sramWrites), 64'(n));

        // Reset while word 3 of an 8-word DRAM -> SRAM transfer is outstanding
        latency = 3;
        for (int i = 0; i < 8; i++) begin
            dram[32'h1000 + 4*i] = 32'h500 + i;
            sram[32'hC0 + i] = 32'hDEAD0000 + i;
        end
        for (int i = 0; i < 3; i++) begin
            expRdReq.push_back(32'h1000 + 4*i);
            expSram.push_back(sramEntry(32'h300, i, 32'h500 + i));
        end
        launch(2'b01, 32'h1000, 32'h300, 8);
        n = 0;
        while (!(bus.dramReadEnable && bus.dramAddress == 32'h100C) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkEq("abort_reached_word3", 64'(bus.dramAddress), 64'h100C);
        #1 reset = 1'b1;
        #1 checkEq("abort_async_outputs", 64'(anyActive), 64'd0);
        @(negedge clk);
        checkEq("abort_next_cycle", 64'(anyActive), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        checkQuiet("abort_quiet", 10);
        for (int i = 0; i < 3; i++) checkEq("abort_sram_moved", 64'(sram[32'hC0 + i]), 64'h500 + i);
        checkEq("abort_sram_w3", 64'(sram[32'hC3]), 64'hDEAD0003);
        checkEq("abort_queues", 64'(expSram.size() + expRdReq.size()), 64'd0);

        // Back-to-back: s2d width 1 then d2s width 1
        latency = 2;
        sram[32'h50] = 32'h77;
        dram[32'h4000] = 32'h99;
        expDramWr.push_back({32'h3000, 32'h77});
        expRdReq.push_back(32'h4000);
        expSram.push_back(sramEntry(32'h200, 0, 32'h99));
        launch(2'b10, 32'h140, 32'h3000, 1);
        waitDone("b2b_s2d_done");
        checkEq("b2b_gap", 64'(bus.stall), 64'd0);
        launch(2'b01, 32'h4000, 32'h200, 1);
        waitDone("b2b_d2s_done");
        checkEq("b2b_order", 64'(lastDramWrCycle < lastSramCycle), 64'd1);
        checkEq("b2b_sram_word", 64'(sram[32'h80]), 64'h99);
        checkEq("b2b_queues", 64'(expSram.size() + expRdReq.size() + expDramWr.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
